// File: rtl/down_counter_timer.sv
// Loadable down-counter/timer. The host loads a count and starts it; the block counts down and pulses done.
// Optional AUTO_RELOAD_EN: at the terminal step, reload the captured value and keep running.
module down_counter_timer #(
  parameter int WIDTH = 3
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             start,
  input  logic             en,
  input  logic             abort,
  output logic [WIDTH-1:0] q,
  output logic             busy,
  output logic             done,
  output logic             zero
);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] q_nxt;
  logic [WIDTH-1:0] reload, reload_nxt;
  logic             done_nxt;
  logic [WIDTH-1:0] start_val;

  always_ff @(posedge clk) begin
    if (!clr_n) begin
      state  <= IDLE;
      q      <= '0;
      reload <= '0;
      done   <= 1'b0;
    end else begin
      state  <= state_nxt;
      q      <= q_nxt;
      reload <= reload_nxt;
      done   <= done_nxt;
    end
  end

  // A load in the same cycle as start takes precedence over the held count
  assign start_val = load ? load_val : q;

  always_comb begin
    state_nxt  = state;
    q_nxt      = q;
    reload_nxt = reload;
    done_nxt   = 1'b0;
    case (state)
      IDLE: begin
        if (load) begin
          q_nxt      = load_val;
          reload_nxt = load_val;
        end
        if (start) begin
          if (start_val != '0) state_nxt = RUN;
          else                 done_nxt  = 1'b1;
        end
      end
      RUN: begin
        if (abort) begin
          state_nxt = IDLE;
        end else if (en) begin
          if (q > WIDTH'(1)) begin
            q_nxt = q - WIDTH'(1);
          end else if (q == WIDTH'(1)) begin
            done_nxt = 1'b1;
`ifdef AUTO_RELOAD_EN
            q_nxt = reload;
`else
            q_nxt     = '0;
            state_nxt = IDLE;
`endif
          end else begin
            // A count of 0 never enters RUN; if it does, drop out rather than underflow
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state == RUN);
  assign zero = (q == '0);

endmodule
